prio_enc_arb: RTL and testbench
===============================

Name: prio_enc_arb

Overview:
- Parametrised, registered successor to the team's 4-input/2-output priority encoder.
- Latches request pulses from N sources into a pending vector and encodes one winner onto a binary index.
- Presents the winner through a valid/ready handshake and clears the served request on acceptance.
- Sits between interrupt/event sources and a single consumer; fixed-priority or round-robin selectable at elaboration.

Parameters:
N, 4, number of request inputs; legal range 2..64.
MODE, 0, 0 = fixed priority (highest index wins); 1 = round-robin.
W (localparam), clog2(N), index width; minimum 1.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  asynchronous, active-high reset.
req_in  input  N  per-source request pulse; bit i high for one or more cycles sets pending[i].
out_ready  input  1  consumer accepts out_idx when high together with out_valid.
out_valid  output  1  out_idx holds a granted request.
out_idx  output  W  binary index of granted source.
pending  output  N  registered outstanding-request vector.

Behaviour:
- Reset (asynchronous, any time, including mid-handshake): pending=0, out_valid=0, out_idx=0, rr_ptr=0, state=IDLE. Requests in flight are discarded.
- pending update, every cycle:
  - pending_next = (pending & ~clr_mask) | req_in.
  - clr_mask is the one-hot of out_idx when out_valid & out_ready, otherwise 0.
  - Set wins: req_in[k] high in the same cycle as acceptance of k keeps pending[k]=1.
- FSM states IDLE and GRANT:
  - IDLE: if pending != 0, register the selected index into out_idx, set out_valid=1, go to GRANT. Otherwise stay.
  - GRANT: out_idx and out_valid hold stable while out_ready=0. New requests may set pending bits but never change out_idx.
  - GRANT with out_ready=1: out_valid=0 next cycle, go to IDLE, served bit cleared as above.
  - No back-to-back grants; minimum 2 cycles per grant. This is intentional: out_idx is always registered.
- Latency: req_in high in cycle t -> pending bit set at edge t+1 -> out_valid at edge t+2 (IDLE, no competitor).
- Selection, MODE=0: highest set index of pending.
- Selection, MODE=1:
  - Search starts at rr_ptr and moves upward, wrapping from N-1 to 0; first set bit wins.
  - On acceptance, rr_ptr = out_idx+1, wrapping N-1 -> 0. rr_ptr is unchanged otherwise.
- Non-power-of-two N: out_idx never exceeds N-1. rr_ptr wraps at N, not 2^W.
- out_ready while out_valid=0 is ignored.
- req_in held high continuously: source is re-pending immediately after each acceptance. In MODE=1 it cannot starve the others.
- Width rules: no truncation; out_idx is zero-extended index. pending is exactly N bits.

Test Plan:
1. Reset, N=4, MODE=0, req_in=4'b0000 for 5 cycles -> out_valid=0, pending=0000, out_idx=00 throughout.
2. N=4, MODE=0, single-cycle pulse req_in=4'b0101, out_ready=1 -> pending=0101; first grant out_idx=2, then out_idx=0; pending=0000 after the second acceptance. Sweep all 16 req_in values: first grant equals highest set bit, matching the 4-to-2 priority encoder table.
3. N=4, MODE=1, req_in held at 4'b1111, out_ready=1 -> grant sequence 0,1,2,3,0,1; pending stays 1111.
4. N=4, MODE=0, hold out_ready=0 for 6 cycles after grant of index 1, then pulse req_in=4'b1000 -> out_idx stays 1, out_valid stays 1, pending=1010. Raise out_ready -> index 1 served, next grant is 3.
5. Set-wins collision: accept index 2 while req_in[2]=1 in the same cycle -> pending[2] remains 1, and index 2 is granted again (MODE=0).
6. N=5, MODE=1, assert rst asynchronously mid-GRANT -> all outputs 0 immediately without a clock edge. Then pulse req_in=5'b10001 -> grants 0 then 4; rr_ptr wraps 4 -> 0; out_idx never takes values 5-7.

Source files
------------

// File: rtl/prio_enc_arb.sv
// Registered N-input priority encoder / arbiter: latches request pulses into a
// pending vector and hands one winner at a time to a valid/ready consumer.
//
// state | meaning
// IDLE  | no grant presented; picks a winner whenever pending is non-zero
// GRANT | out_idx/out_valid held stable until the consumer raises out_ready
module prio_enc_arb #(
    parameter int N    = 4,
    parameter int MODE = 0,
    localparam int W   = (N > 1) ? $clog2(N) : 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req_in,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [W-1:0] out_idx,
    output logic [N-1:0] pending
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t         state;
    state_t         state_next;
    logic [W-1:0]   rr_ptr;
    logic [W-1:0]   rr_next;
    logic [W-1:0]   idx_next;
    logic           valid_next;
    logic [N-1:0]   pending_next;
    logic [N-1:0]   clr_mask;
    logic [W-1:0]   sel_idx;
    logic [W:0]     cand;
    logic           accept;

    assign accept = out_valid & out_ready;

    // Winner selection from the registered pending vector.
    always_comb begin
        sel_idx = '0;
        cand    = '0;
        if (MODE == 0) begin
            for (int i = 0; i < N; i++) begin
                if (pending[i]) sel_idx = W'(i);
            end
        end else begin
            // Walk offsets from farthest to nearest so the first set bit at or
            // above rr_ptr (wrapping at N, not 2^W) is the last one assigned.
            for (int k = N - 1; k >= 0; k--) begin
                cand = {1'b0, rr_ptr} + (W + 1)'(k);
                if (cand >= (W + 1)'(N)) cand = cand - (W + 1)'(N);
                if (pending[cand[W-1:0]]) sel_idx = cand[W-1:0];
            end
        end
    end

    always_comb begin
        state_next = state;
        idx_next   = out_idx;
        valid_next = out_valid;
        rr_next    = rr_ptr;
        clr_mask   = '0;

        if (accept) clr_mask[out_idx] = 1'b1;

        case (state)
            IDLE: begin
                if (|pending) begin
                    idx_next   = sel_idx;
                    valid_next = 1'b1;
                    state_next = GRANT;
                end
            end
            GRANT: begin
                if (out_ready) begin
                    valid_next = 1'b0;
                    state_next = IDLE;
                    rr_next    = (out_idx == W'(N - 1)) ? '0 : out_idx + W'(1);
                end
            end
            default: begin
                state_next = IDLE;
                valid_next = 1'b0;
            end
        endcase

        // A request arriving in the same cycle as its own acceptance survives.
        pending_next = (pending & ~clr_mask) | req_in;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            out_idx   <= '0;
            out_valid <= 1'b0;
            rr_ptr    <= '0;
            pending   <= '0;
        end else begin
            state     <= state_next;
            out_idx   <= idx_next;
            out_valid <= valid_next;
            rr_ptr    <= rr_next;
            pending   <= pending_next;
        end
    end

endmodule

// File: tb/tb_prio_enc_arb.sv
// Directed bench for prio_enc_arb: fixed-priority N=4, round-robin N=4 and
// round-robin N=5 instances driven with hand-computed expectations.
module tb_prio_enc_arb;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic [3:0] req_a = '0;
    logic       rdy_a = 1'b0;
    logic       vld_a;
    logic [1:0] idx_a;
    logic [3:0] pend_a;

    logic [3:0] req_b = '0;
    logic       rdy_b = 1'b0;
    logic       vld_b;
    logic [1:0] idx_b;
    logic [3:0] pend_b;

    logic [4:0] req_c = '0;
    logic       rdy_c = 1'b0;
    logic       vld_c;
    logic [2:0] idx_c;
    logic [4:0] pend_c;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    prio_enc_arb #(.N(4), .MODE(0)) dut_a (
        .clk(clk), .rst(rst), .req_in(req_a), .out_ready(rdy_a),
        .out_valid(vld_a), .out_idx(idx_a), .pending(pend_a)
    );

    prio_enc_arb #(.N(4), .MODE(1)) dut_b (
        .clk(clk), .rst(rst), .req_in(req_b), .out_ready(rdy_b),
        .out_valid(vld_b), .out_idx(idx_b), .pending(pend_b)
    );

    prio_enc_arb #(.N(5), .MODE(1)) dut_c (
        .clk(clk), .rst(rst), .req_in(req_c), .out_ready(rdy_c),
        .out_valid(vld_c), .out_idx(idx_c), .pending(pend_c)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    int hi_tab[16] = '{0, 0, 1, 1, 2, 2, 2, 2, 3, 3, 3, 3, 3, 3, 3, 3};
    int rr_seq[6]  = '{0, 1, 2, 3, 0, 1};

    initial begin
        // 1: reset and quiet inputs
        tick(2);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t1_valid", 64'(vld_a), 64'd0);
            chk("t1_pend",  64'(pend_a), 64'd0);
            chk("t1_idx",   64'(idx_a), 64'd0);
        end

        // 2: pulse 0101, ready high
        req_a = 4'b0101; rdy_a = 1'b1;
        tick(); req_a = 4'b0000;
        chk("t2_pend_set", 64'(pend_a), 64'h5);
        chk("t2_valid0",   64'(vld_a), 64'd0);
        tick();
        chk("t2_g1_valid", 64'(vld_a), 64'd1);
        chk("t2_g1_idx",   64'(idx_a), 64'd2);
        tick();
        chk("t2_acc1_valid", 64'(vld_a), 64'd0);
        chk("t2_acc1_pend",  64'(pend_a), 64'h1);
        tick();
        chk("t2_g2_idx",   64'(idx_a), 64'd0);
        chk("t2_g2_valid", 64'(vld_a), 64'd1);
        tick();
        chk("t2_pend_empty", 64'(pend_a), 64'h0);
        chk("t2_valid_off",  64'(vld_a), 64'd0);

        // 2: sweep all request patterns, first grant = highest set bit
        for (int v = 0; v < 16; v++) begin
            rdy_a = 1'b0;
            req_a = 4'(v);
            tick(); req_a = 4'b0000;
            tick();
            chk("t2_sweep_valid", 64'(vld_a), (v != 0) ? 64'd1 : 64'd0);
            if (v != 0) chk("t2_sweep_idx", 64'(idx_a), 64'(hi_tab[v]));
            rdy_a = 1'b1;
            tick(12);
            chk("t2_sweep_drain", 64'(pend_a), 64'h0);
        end
        rdy_a = 1'b0;
        tick();

        // 3: round-robin with all requests held
        req_b = 4'b1111; rdy_b = 1'b1;
        tick();
        chk("t3_pend", 64'(pend_b), 64'hf);
        for (int g = 0; g < 6; g++) begin
            tick();
            chk("t3_valid", 64'(vld_b), 64'd1);
            chk("t3_idx",   64'(idx_b), 64'(rr_seq[g]));
            tick();
            chk("t3_acc_valid", 64'(vld_b), 64'd0);
            chk("t3_acc_pend",  64'(pend_b), 64'hf);
        end
        req_b = 4'b0000; rdy_b = 1'b0;

        // 4: stall with out_ready low, a late request must not disturb the grant
        req_a = 4'b0010;
        tick(); req_a = 4'b0000;
        tick();
        chk("t4_grant_idx", 64'(idx_a), 64'd1);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("t4_hold_idx",   64'(idx_a), 64'd1);
            chk("t4_hold_valid", 64'(vld_a), 64'd1);
        end
        req_a = 4'b1000;
        tick(); req_a = 4'b0000;
        tick();
        chk("t4_pend",      64'(pend_a), 64'ha);
        chk("t4_still_idx", 64'(idx_a), 64'd1);
        rdy_a = 1'b1;
        tick();
        chk("t4_served_pend", 64'(pend_a), 64'h8);
        chk("t4_served_vld",  64'(vld_a), 64'd0);
        tick();
        chk("t4_next_idx", 64'(idx_a), 64'd3);
        chk("t4_next_vld", 64'(vld_a), 64'd1);
        tick();
        chk("t4_drain", 64'(pend_a), 64'h0);
        rdy_a = 1'b0;

        // 5: set wins over clear on the same index
        req_a = 4'b0100;
        tick(); req_a = 4'b0000;
        tick();
        chk("t5_grant_idx", 64'(idx_a), 64'd2);
        req_a = 4'b0100; rdy_a = 1'b1;
        tick(); req_a = 4'b0000;
        chk("t5_pend_kept", 64'(pend_a), 64'h4);
        chk("t5_acc_vld",   64'(vld_a), 64'd0);
        tick();
        chk("t5_regrant_idx", 64'(idx_a), 64'd2);
        chk("t5_regrant_vld", 64'(vld_a), 64'd1);
        tick();
        chk("t5_drain", 64'(pend_a), 64'h0);
        rdy_a = 1'b0;

        // 6: N=5 round-robin; move rr_ptr off zero, then reset mid-grant
        req_c = 5'b00001; rdy_c = 1'b1;
        tick(); req_c = 5'b00000;
        tick();
        chk("t6_pre_idx", 64'(idx_c), 64'd0);
        tick();
        rdy_c = 1'b0;
        req_c = 5'b00100;
        tick(); req_c = 5'b00000;
        tick();
        chk("t6_pre2_vld", 64'(vld_c), 64'd1);
        chk("t6_pre2_idx", 64'(idx_c), 64'd2);
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_vld",  64'(vld_c), 64'd0);
        chk("t6_rst_idx",  64'(idx_c), 64'd0);
        chk("t6_rst_pend", 64'(pend_c), 64'd0);
        tick();
        rst = 1'b0;
        req_c = 5'b10001; rdy_c = 1'b1;
        tick(); req_c = 5'b00000;
        chk("t6_pend", 64'(pend_c), 64'h11);
        tick();
        chk("t6_g1_idx", 64'(idx_c), 64'd0);
        chk("t6_g1_vld", 64'(vld_c), 64'd1);
        tick();
        chk("t6_acc1_pend", 64'(pend_c), 64'h10);
        tick();
        chk("t6_g2_idx", 64'(idx_c), 64'd4);
        tick();
        chk("t6_acc2_pend", 64'(pend_c), 64'h0);
        // rr_ptr should have wrapped from 4 to 0: index 0 wins over 3
        req_c = 5'b01001;
        tick(); req_c = 5'b00000;
        for (int g = 0; g < 2; g++) begin
            tick();
            chk("t6_wrap_idx", 64'(idx_c), (g == 0) ? 64'd0 : 64'd3);
            chk("t6_idx_range", 64'(idx_c <= 3'd4), 64'd1);
            tick();
        end
        chk("t6_final_pend", 64'(pend_c), 64'h0);
        rdy_c = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
